// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle for the 16-bit TSC multi-cycle datapath.
// master: the control unit (consumes IR/bcond/ack, drives selects and enables).
// slave:  the datapath / memory side.
interface multicycle_control_unit_if #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
);
  logic [WORD_SIZE-1:0] instr;
  logic                 bcond;
  logic                 mem_ack;

  logic                 pc_write;
  logic                 pc_write_cond;
  logic [1:0]           pc_source;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic [1:0]           reg_dst;
  logic [1:0]           wb_sel;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic                 output_valid;
  logic                 is_halted;
  logic [CNT_WIDTH-1:0] num_inst;

  modport master (
    input  instr, bcond, mem_ack,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b,
           output_valid, is_halted, num_inst
  );

  modport slave (
    output instr, bcond, mem_ack,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b,
           output_valid, is_halted, num_inst
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM control unit for the 16-bit TSC datapath.
// Sequences IF/ID/EX/MEM/WB, waits on mem_ack in IF and MEM, counts retired
// instructions in num_inst.
// Optional macro ILLEGAL_TRAP_EN: undefined opcodes/funcodes trap to HALT and
// raise illegal_instr; otherwise they behave as a counted 2-cycle NOP.
module multicycle_control_unit #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  multicycle_control_unit_if.master bus
`ifdef ILLEGAL_TRAP_EN
  , output logic                    illegal_instr
`endif
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_BNE = 4'd0,  OP_BEQ = 4'd1,  OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3,  OP_ADI = 4'd4,  OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6,  OP_LWD = 4'd7,  OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9,  OP_JAL = 4'd10, OP_ALU = 4'd15;

  localparam logic [5:0] FN_SHR = 6'd7,  FN_JPR = 6'd25, FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28, FN_HLT = 6'd29;

  state_t state, state_next;

  logic [3:0] opcode;
  logic [5:0] funct;
  logic       is_alu_fn;
  logic       retire;
  logic       trap;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       ir_write_c, reg_write_c, alu_src_a_c, output_valid_c, is_halted_c;
  logic [1:0] pc_source_c, reg_dst_c, wb_sel_c, alu_src_b_c;

  logic [CNT_WIDTH-1:0] num_inst_q;

  assign opcode    = bus.instr[WORD_SIZE-1:WORD_SIZE-4];
  assign funct     = bus.instr[5:0];
  assign is_alu_fn = (funct <= FN_SHR);

  // Register fields and bcond are consumed by the datapath, not by this FSM.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.instr[WORD_SIZE-5:6], bus.bcond};

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset_n) state <= S_IF;
    else          state <= state_next;
  end

  // Next-state and Moore control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next      = state;
    retire          = 1'b0;
    trap            = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_source_c     = 2'd0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    reg_dst_c       = 2'd0;
    wb_sel_c        = 2'd0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'd0;
    output_valid_c  = 1'b0;
    is_halted_c     = 1'b0;

    unique case (state)
      S_IF: begin
        mem_read_c = 1'b1;
        if (bus.mem_ack) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = S_ID;
        end
      end

      S_ID: begin
        // Undefined encodings fall through to this default path.
`ifdef ILLEGAL_TRAP_EN
        trap       = 1'b1;
        state_next = S_HALT;
`else
        retire     = 1'b1;
        state_next = S_IF;
`endif
        case (opcode)
          OP_JMP: begin
            trap = 1'b0; retire = 1'b1; state_next = S_IF;
            pc_write_c = 1'b1; pc_source_c = 2'd2;
          end
          OP_JAL: begin
            trap = 1'b0; retire = 1'b1; state_next = S_IF;
            pc_write_c = 1'b1; pc_source_c = 2'd2;
            reg_write_c = 1'b1; reg_dst_c = 2'd2; wb_sel_c = 2'd2;
          end
          OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ, OP_ADI, OP_ORI,
          OP_LHI, OP_LWD, OP_SWD: begin
            trap = 1'b0; retire = 1'b0; state_next = S_EX;
          end
          OP_ALU: begin
            if (is_alu_fn) begin
              trap = 1'b0; retire = 1'b0; state_next = S_EX;
            end else if (funct == FN_JPR) begin
              trap = 1'b0; retire = 1'b1; state_next = S_IF;
              pc_write_c = 1'b1; pc_source_c = 2'd3;
            end else if (funct == FN_JRL) begin
              trap = 1'b0; retire = 1'b1; state_next = S_IF;
              pc_write_c = 1'b1; pc_source_c = 2'd3;
              reg_write_c = 1'b1; reg_dst_c = 2'd2; wb_sel_c = 2'd2;
            end else if (funct == FN_WWD) begin
              trap = 1'b0; retire = 1'b1; state_next = S_IF;
              output_valid_c = 1'b1;
            end else if (funct == FN_HLT) begin
              trap = 1'b0; retire = 1'b1; state_next = S_HALT;
            end
          end
          default: ;
        endcase
      end

      S_EX: begin
        state_next = S_IF;
        case (opcode)
          OP_ALU: begin
            alu_src_a_c = 1'b1;
            state_next  = S_WB;
          end
          OP_ADI, OP_ORI, OP_LHI: begin
            alu_src_b_c = 2'd2;
            state_next  = S_WB;
          end
          OP_LWD, OP_SWD: begin
            alu_src_b_c = 2'd2;
            state_next  = S_MEM;
          end
          OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
            alu_src_a_c     = 1'b1;
            pc_write_cond_c = 1'b1;
            pc_source_c     = 2'd1;
            retire          = 1'b1;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        i_or_d_c    = 1'b1;
        mem_read_c  = (opcode == OP_LWD);
        mem_write_c = (opcode == OP_SWD);
        if (bus.mem_ack) begin
          if (opcode == OP_LWD) begin
            state_next = S_WB;
          end else begin
            retire     = 1'b1;
            state_next = S_IF;
          end
        end
      end

      S_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = (opcode == OP_ALU) ? 2'd1 : 2'd0;
        wb_sel_c    = (opcode == OP_LWD) ? 2'd1 : 2'd0;
        retire      = 1'b1;
        state_next  = S_IF;
      end

      S_HALT: is_halted_c = 1'b1;

      default: state_next = S_IF;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) num_inst_q <= '0;
    else          num_inst_q <= num_inst_q + CNT_WIDTH'(retire);
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  illegal_instr <= 1'b0;
    else if (trap) illegal_instr <= 1'b1;
  end
`else
  logic unused_trap;
  assign unused_trap = trap;
`endif

  // Reset holds every control low, including the IF fetch request.
  assign bus.pc_write      = reset_n & pc_write_c;
  assign bus.pc_write_cond = reset_n & pc_write_cond_c;
  assign bus.pc_source     = reset_n ? pc_source_c : 2'd0;
  assign bus.i_or_d        = reset_n & i_or_d_c;
  assign bus.mem_read      = reset_n & mem_read_c;
  assign bus.mem_write     = reset_n & mem_write_c;
  assign bus.ir_write      = reset_n & ir_write_c;
  assign bus.reg_write     = reset_n & reg_write_c;
  assign bus.reg_dst       = reset_n ? reg_dst_c : 2'd0;
  assign bus.wb_sel        = reset_n ? wb_sel_c : 2'd0;
  assign bus.alu_src_a     = reset_n & alu_src_a_c;
  assign bus.alu_src_b     = reset_n ? alu_src_b_c : 2'd0;
  assign bus.output_valid  = reset_n & output_valid_c;
  assign bus.is_halted     = reset_n & is_halted_c;
  assign bus.num_inst      = num_inst_q;

endmodule
